regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_rd_port.sv | 53 +++++
 rtl/regfile_mp.sv | 85 ++++++++
 tb/tb_regfile_mp.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file: default geometry and
// RISC-V ABI register indices used by decode and test code.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;

  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 1;
  localparam int REG_SP   = 2;
  localparam int REG_GP   = 3;
  localparam int REG_TP   = 4;
  localparam int REG_T0   = 5;
  localparam int REG_T1   = 6;
  localparam int REG_T2   = 7;
  localparam int REG_S0   = 8;
  localparam int REG_S1   = 9;
  localparam int REG_A0   = 10;
  localparam int REG_A1   = 11;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: scoreboard-gated acceptance, same-cycle write bypass,
// x0 forcing and the registered data/ack outputs.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREGS   = NREGS_DEF,
  parameter int ZERO_X0 = 1,
  parameter int AW      = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    addr,
  input  logic             addr_valid,
  input  logic [NREGS-1:0] busy,
  input  logic [XLEN-1:0]  reg_data,
  input  logic [AW-1:0]    wr_addr,
  input  logic [XLEN-1:0]  wr_data,
  input  logic             wr_data_valid,
  output logic [XLEN-1:0]  data,
  output logic             ack
);

  logic            hit;
  logic            accept;
  logic            is_zero;
  logic [XLEN-1:0] sel_data;

  assign hit     = wr_data_valid && (wr_addr == addr);
  assign is_zero = (ZERO_X0 != 0) && (addr == '0);
  // The busy bit is the pre-reservation value, so a same-cycle reservation
  // never stalls this read; a landing write unblocks it through the bypass.
  assign accept  = addr_valid && (!busy[addr] || hit);

  always_comb begin
    // NOTE: default assignment first so every path drives sel_data and no latch is inferred.
    sel_data = reg_data;
    if (is_zero) sel_data = '0;
    else if (hit) sel_data = wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
      ack  <= 1'b0;
    end else begin
      ack <= accept;
      if (accept) data <= sel_data;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with NRD read ports, one write port, x0 tied
// to zero, write-to-read bypass and a per-register busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREGS   = NREGS_DEF,
  parameter int NRD     = NRD_DEF,
  parameter int ZERO_X0 = 1,
  parameter int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  input  logic [NRD-1:0]      rd_addr_valid,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_data_ack,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                wr_data_valid,
  output logic                wr_ack,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                rsv_valid,
  output logic [NREGS-1:0]    busy
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_next;
  logic             wr_en;
  logic             rsv_en;

  assign wr_en  = wr_data_valid && !((ZERO_X0 != 0) && (wr_addr == '0));
  assign rsv_en = rsv_valid && !((ZERO_X0 != 0) && (rsv_addr == '0));

  // NOTE: the array is reset explicitly because software expects all registers to read zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // The set follows the clear so a same-cycle reservation (newer producer) wins.
  always_comb begin
    busy_next = busy;
    if (wr_data_valid) busy_next[wr_addr] = 1'b0;
    if (rsv_en) busy_next[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= '0;
      wr_ack <= 1'b0;
    end else begin
      busy   <= busy_next;
      wr_ack <= wr_data_valid;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] port_addr;
    assign port_addr = rd_addr[p*AW +: AW];

    regfile_rd_port #(
      .XLEN    (XLEN),
      .NREGS   (NREGS),
      .ZERO_X0 (ZERO_X0),
      .AW      (AW)
    ) u_port (
      .clk           (clk),
      .reset         (reset),
      .addr          (port_addr),
      .addr_valid    (rd_addr_valid[p]),
      .busy          (busy),
      .reg_data      (regs[port_addr]),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .wr_data_valid (wr_data_valid),
      .data          (rd_data[p*XLEN +: XLEN]),
      .ack           (rd_data_ack[p])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed scenarios then random traffic,
// checked against an array-based model of the register file rules.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = $clog2(NREGS);

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD-1:0]      rd_addr_valid;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_data_ack;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                wr_data_valid;
  logic                wr_ack;
  logic [AW-1:0]       rsv_addr;
  logic                rsv_valid;
  logic [NREGS-1:0]    busy;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_X0(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .rd_addr       (rd_addr),
    .rd_addr_valid (rd_addr_valid),
    .rd_data       (rd_data),
    .rd_data_ack   (rd_data_ack),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_data_valid (wr_data_valid),
    .wr_ack        (wr_ack),
    .rsv_addr      (rsv_addr),
    .rsv_valid     (rsv_valid),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic [XLEN-1:0] data;
  } rd_exp_t;

  typedef struct {
    int               cyc;
    logic             rst;
    logic [NREGS-1:0] busy;
    logic             wr_ack;
  } st_exp_t;

  rd_exp_t rd_q [NRD][$];
  st_exp_t st_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [XLEN-1:0]  m_regs [NREGS];
  logic [NREGS-1:0] m_busy;
  logic [XLEN-1:0]  last_data [NRD];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs and record what the register file must answer.
  task automatic step(input logic rst,
                      input logic v0, input logic [AW-1:0] a0,
                      input logic v1, input logic [AW-1:0] a1,
                      input logic wv, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                      input logic rv, input logic [AW-1:0] ra);
    logic [AW-1:0] a [NRD];
    logic          v [NRD];
    st_exp_t       st;
    a[0] = a0; a[1] = a1; v[0] = v0; v[1] = v1;
    reset = rst;
    for (int p = 0; p < NRD; p++) begin
      rd_addr[p*AW +: AW] = a[p];
      rd_addr_valid[p]    = v[p];
    end
    wr_data_valid = wv; wr_addr = wa; wr_data = wd;
    rsv_valid = rv; rsv_addr = ra;

    if (rst) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      m_busy = '0;
    end else begin
      for (int p = 0; p < NRD; p++) begin
        bit same_wr;
        rd_exp_t e;
        same_wr = wv && (wa == a[p]);
        if (v[p] && (!m_busy[a[p]] || same_wr)) begin
          e.cyc = cyc + 1;
          if (a[p] == 0) e.data = '0;
          else if (same_wr) e.data = wd;
          else e.data = m_regs[a[p]];
          rd_q[p].push_back(e);
        end
      end
      if (wv && wa != 0) m_regs[wa] = wd;
      if (wv) m_busy[wa] = 1'b0;
      if (rv && ra != 0) m_busy[ra] = 1'b1;
    end
    st.cyc = cyc + 1; st.rst = rst; st.busy = m_busy; st.wr_ack = rst ? 1'b0 : wv;
    st_q.push_back(st);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, '0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
      st_exp_t st;
      st = st_q.pop_front();
      check("busy", 64'(busy), 64'(st.busy));
      check("wr_ack", 64'(wr_ack), 64'(st.wr_ack));
      if (st.rst) for (int p = 0; p < NRD; p++) last_data[p] = '0;
      for (int p = 0; p < NRD; p++) begin
        logic [XLEN-1:0] d;
        bit due;
        d = rd_data[p*XLEN +: XLEN];
        due = rd_q[p].size() > 0 && rd_q[p][0].cyc == cyc;
        if (rd_data_ack[p]) begin
          if (due) begin
            rd_exp_t e;
            e = rd_q[p].pop_front();
            check($sformatf("rd_data[%0d]", p), 64'(d), 64'(e.data));
            last_data[p] = e.data;
          end else begin
            check($sformatf("unexpected_ack[%0d]", p), 64'(1), 64'(0));
          end
        end else begin
          if (due) begin
            void'(rd_q[p].pop_front());
            check($sformatf("missing_ack[%0d]", p), 64'(0), 64'(1));
          end
          check($sformatf("rd_hold[%0d]", p), 64'(d), 64'(last_data[p]));
        end
      end
    end
  end

  initial begin
    reset = 1'b1; rd_addr = '0; rd_addr_valid = '0;
    wr_addr = '0; wr_data = '0; wr_data_valid = 1'b0;
    rsv_addr = '0; rsv_valid = 1'b0;
    m_busy = '0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    for (int p = 0; p < NRD; p++) last_data[p] = '0;
    @(posedge clk);
    #1;

    step(1, 0, 0, 0, 0, 0, 0, '0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, '0, 0, 0);
    step(0, 1, 5, 1, 7, 0, 0, '0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 3, 32'hDEADBEEF, 0, 0);
    step(0, 1, 3, 1, 3, 0, 0, '0, 0, 0);
    step(0, 1, 9, 0, 0, 1, 9, 32'h12345678, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, '0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, '0, 1, 4);
    repeat (3) step(0, 1, 4, 0, 0, 0, 0, '0, 0, 0);
    step(0, 1, 4, 0, 0, 1, 4, 32'hA5A5A5A5, 0, 0);
    idle();
    step(0, 0, 0, 0, 0, 1, 6, 32'h1, 1, 6);
    repeat (2) step(0, 1, 6, 1, 6, 0, 0, '0, 0, 0);
    step(1, 1, 6, 1, 6, 0, 0, '0, 0, 0);
    step(0, 1, 6, 0, 0, 0, 0, '0, 0, 0);
    idle();

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0),
           1'($urandom), AW'($urandom_range(0, 7)),
           1'($urandom), AW'($urandom_range(0, 7)),
           1'($urandom), AW'($urandom_range(0, 7)), $urandom(),
           ($urandom_range(0, 3) == 0), AW'($urandom_range(0, 7)));
    end
    repeat (3) idle();
    @(negedge clk);
    #1;
    for (int p = 0; p < NRD; p++)
      check($sformatf("pending_reads[%0d]", p), 64'(rd_q[p].size()), 64'(0));
    check("pending_status", 64'(st_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
